// File: rtl/msk_rx_acq_pkg.sv
// Shared types and defaults for the MSK receive acquisition sequencer.
// Holds the sequencer state encoding, the default parameter values and a
// saturating magnitude helper used by the lock detectors.
package msk_rx_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TIM_ACQ = 3'd1,
    ST_CFO_EST = 3'd2,
    ST_CAR_ACQ = 3'd3,
    ST_LOCKED  = 3'd4
  } acq_state_t;

  localparam int TED_W_DEF      = 18;
  localparam int PED_W_DEF      = 24;
  localparam int FW_DEF         = 32;
  localparam int CNT_W_DEF      = 16;
  localparam int TED_THR_DEF    = 2048;
  localparam int TED_LOCK_N_DEF = 64;
  localparam int PED_THR_DEF    = 65536;
  localparam int PED_LOCK_N_DEF = 128;
  localparam int UNLOCK_N_DEF   = 32;
  localparam int TIM_TO_DEF     = 4096;
  localparam int CFO_TO_DEF     = 1024;
  localparam int CAR_TO_DEF     = 4096;

  // Widest error word the magnitude helper handles; narrower errors are
  // sign-extended into it.
  localparam int ERR_MAX_W = 32;

  // Magnitude of a sign-extended error. The most-negative value of the
  // original width has no positive counterpart and saturates to pos_max.
  function automatic logic [ERR_MAX_W-1:0] sat_abs(
    input logic [ERR_MAX_W-1:0] x,
    input logic                 is_min,
    input logic [ERR_MAX_W-1:0] pos_max
  );
    logic [ERR_MAX_W-1:0] r;
    if (is_min) begin
      r = pos_max;
    end else if (x[ERR_MAX_W-1]) begin
      r = (~x) + {{(ERR_MAX_W-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/msk_rx_acq_ctrl_lock_det.sv
// Lock detector: classifies each qualified error sample as good
// (|err| < THR) or bad, and tracks the current good-run and bad-run lengths.
// good_hit / bad_hit flag the sample that completes a run of N_GOOD / N_BAD,
// combinationally, so the sequencer can act on the following edge.
// Ports: clk, reset_n (async, active-low), clr (sync clear), err (signed W),
//        val (err qualifier), good_hit, bad_hit.
module msk_lock_det
  import msk_rx_acq_pkg::*;
#(
  parameter int W      = 18,
  parameter int THR    = 2048,
  parameter int N_GOOD = 64,
  parameter int N_BAD  = 32,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic [W-1:0] err,
  input  logic         val,
  output logic         good_hit,
  output logic         bad_hit
);

  localparam logic [ERR_MAX_W-1:0] POS_MAX   = ERR_MAX_W'((64'd1 << (W - 1)) - 64'd1);
  localparam logic [ERR_MAX_W-1:0] THR_V     = ERR_MAX_W'(THR);
  localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]     GOOD_LAST = CNT_W'(N_GOOD - 1);
  localparam logic [CNT_W-1:0]     BAD_LAST  = CNT_W'(N_BAD - 1);

  logic signed [W-1:0]   err_sgn_s;
  logic [ERR_MAX_W-1:0]  err_ext_s;
  logic [ERR_MAX_W-1:0]  mag_s;
  logic                  is_min_s;
  logic                  good_s;
  logic [CNT_W-1:0]      good_cnt_r;
  logic [CNT_W-1:0]      bad_cnt_r;

  assign err_sgn_s = err;
  assign err_ext_s = ERR_MAX_W'(err_sgn_s);
  assign is_min_s  = err[W-1] && (err[W-2:0] == '0);
  assign mag_s     = sat_abs(err_ext_s, is_min_s, POS_MAX);
  // The saturated most-negative value is bad regardless of threshold.
  assign good_s    = !is_min_s && (mag_s < THR_V);

  assign good_hit  = val && good_s && (good_cnt_r >= GOOD_LAST);
  assign bad_hit   = val && !good_s && (bad_cnt_r >= BAD_LAST);

  // Run-length counters: a sample of one kind restarts the other run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good_cnt_r <= '0;
      bad_cnt_r  <= '0;
    end else if (clr) begin
      good_cnt_r <= '0;
      bad_cnt_r  <= '0;
    end else if (val) begin
      if (good_s) begin
        good_cnt_r <= (good_cnt_r == CNT_MAX) ? good_cnt_r : good_cnt_r + 1'b1;
        bad_cnt_r  <= '0;
      end else begin
        bad_cnt_r  <= (bad_cnt_r == CNT_MAX) ? bad_cnt_r : bad_cnt_r + 1'b1;
        good_cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/msk_rx_acq_ctrl.sv
// MSK receive acquisition sequencer. Brings up symbol timing, then the
// coarse CFO estimate, then the carrier loop, qualifying each with a lock
// detector, and falls back a stage on timeout or loss of lock.
// Ports: clk, reset_n, start_i (level enable), sym_val_i (symbol strobe),
//        ted_err_i/ted_val_i, cfo_done_i/cfo_word_i, ped_err_i/ped_val_i;
//        outputs timing_en_o, cfo_en_o, carrier_en_o, freq_load_o,
//        freq_word_o, lock_o, acq_fail_o, state_o. All outputs registered.
module msk_rx_acq_ctrl
  import msk_rx_acq_pkg::*;
#(
  parameter int TED_W      = TED_W_DEF,
  parameter int PED_W      = PED_W_DEF,
  parameter int FW         = FW_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TED_THR    = TED_THR_DEF,
  parameter int TED_LOCK_N = TED_LOCK_N_DEF,
  parameter int PED_THR    = PED_THR_DEF,
  parameter int PED_LOCK_N = PED_LOCK_N_DEF,
  parameter int UNLOCK_N   = UNLOCK_N_DEF,
  parameter int TIM_TO     = TIM_TO_DEF,
  parameter int CFO_TO     = CFO_TO_DEF,
  parameter int CAR_TO     = CAR_TO_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             sym_val_i,
  input  logic [TED_W-1:0] ted_err_i,
  input  logic             ted_val_i,
  input  logic             cfo_done_i,
  input  logic [FW-1:0]    cfo_word_i,
  input  logic [PED_W-1:0] ped_err_i,
  input  logic             ped_val_i,
  output logic             timing_en_o,
  output logic             cfo_en_o,
  output logic             carrier_en_o,
  output logic             freq_load_o,
  output logic [FW-1:0]    freq_word_o,
  output logic             lock_o,
  output logic             acq_fail_o,
  output logic [2:0]       state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIM_LAST = CNT_W'(TIM_TO - 1);
  localparam logic [CNT_W-1:0] CFO_LAST = CNT_W'(CFO_TO - 1);
  localparam logic [CNT_W-1:0] CAR_LAST = CNT_W'(CAR_TO - 1);

  acq_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] sym_cnt_r, to_last_s;
  logic             in_acq_s, timeout_s, fail_s, latch_s, entry_s;
  logic             ted_good_hit_s, ted_bad_hit_s, ped_good_hit_s, ped_bad_hit_s;
  logic             timing_en_r, cfo_en_r, carrier_en_r, freq_load_r, lock_r, acq_fail_r;
  logic [FW-1:0]    freq_word_r;

  msk_lock_det #(.W(TED_W), .THR(TED_THR), .N_GOOD(TED_LOCK_N), .N_BAD(UNLOCK_N), .CNT_W(CNT_W))
    u_ted_det (.clk(clk), .reset_n(reset_n), .clr(entry_s), .err(ted_err_i), .val(ted_val_i),
               .good_hit(ted_good_hit_s), .bad_hit(ted_bad_hit_s));

  msk_lock_det #(.W(PED_W), .THR(PED_THR), .N_GOOD(PED_LOCK_N), .N_BAD(UNLOCK_N), .CNT_W(CNT_W))
    u_ped_det (.clk(clk), .reset_n(reset_n), .clr(entry_s), .err(ped_err_i), .val(ped_val_i),
               .good_hit(ped_good_hit_s), .bad_hit(ped_bad_hit_s));

  // Select the symbol budget of the current acquisition stage.
  always_comb begin
    to_last_s = CNT_MAX;
    in_acq_s  = 1'b0;
    case (state_r)
      ST_TIM_ACQ: begin to_last_s = TIM_LAST; in_acq_s = 1'b1; end
      ST_CFO_EST: begin to_last_s = CFO_LAST; in_acq_s = 1'b1; end
      ST_CAR_ACQ: begin to_last_s = CAR_LAST; in_acq_s = 1'b1; end
      default:    begin to_last_s = CNT_MAX;  in_acq_s = 1'b0; end
    endcase
  end

  // The strobe that would make the count reach the budget fires the timeout.
  assign timeout_s = sym_val_i && in_acq_s && (sym_cnt_r >= to_last_s);

  // Next-state logic; priority is start_i > cfo_done_i > timeout > lock/unlock.
  always_comb begin
    state_nxt_s = state_r;
    fail_s      = 1'b0;
    latch_s     = 1'b0;
    if (!start_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_TIM_ACQ;
        ST_TIM_ACQ: begin
          if (timeout_s) begin
            fail_s      = 1'b1;
            state_nxt_s = ST_TIM_ACQ;
          end else if (ted_good_hit_s) begin
            state_nxt_s = ST_CFO_EST;
          end else begin
            state_nxt_s = ST_TIM_ACQ;
          end
        end
        ST_CFO_EST: begin
          if (cfo_done_i) begin
            latch_s     = 1'b1;
            state_nxt_s = ST_CAR_ACQ;
          end else if (timeout_s) begin
            fail_s      = 1'b1;
            state_nxt_s = ST_TIM_ACQ;
          end else begin
            state_nxt_s = ST_CFO_EST;
          end
        end
        ST_CAR_ACQ: begin
          if (timeout_s) begin
            fail_s      = 1'b1;
            state_nxt_s = ST_CFO_EST;
          end else if (ped_good_hit_s) begin
            state_nxt_s = ST_LOCKED;
          end else begin
            state_nxt_s = ST_CAR_ACQ;
          end
        end
        ST_LOCKED: begin
          if (ted_bad_hit_s) begin
            state_nxt_s = ST_TIM_ACQ;
          end else if (ped_bad_hit_s) begin
            state_nxt_s = ST_CAR_ACQ;
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // A timeout re-entry counts as a state entry even when the state is unchanged.
  assign entry_s = (state_nxt_s != state_r) || fail_s;

  // State register and Moore outputs registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      timing_en_r  <= 1'b0;
      cfo_en_r     <= 1'b0;
      carrier_en_r <= 1'b0;
      freq_load_r  <= 1'b0;
      lock_r       <= 1'b0;
      acq_fail_r   <= 1'b0;
      freq_word_r  <= '0;
    end else begin
      state_r      <= state_nxt_s;
      timing_en_r  <= (state_nxt_s != ST_IDLE);
      cfo_en_r     <= (state_nxt_s == ST_CFO_EST);
      carrier_en_r <= (state_nxt_s == ST_CAR_ACQ) || (state_nxt_s == ST_LOCKED);
      lock_r       <= (state_nxt_s == ST_LOCKED);
      freq_load_r  <= entry_s && (state_nxt_s == ST_CAR_ACQ);
      acq_fail_r   <= fail_s;
      if (latch_s) begin
        freq_word_r <= cfo_word_i;
      end
    end
  end

  // Saturating symbol counter for the stage timeouts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_cnt_r <= '0;
    end else if (entry_s) begin
      sym_cnt_r <= '0;
    end else if (sym_val_i && (sym_cnt_r != CNT_MAX)) begin
      sym_cnt_r <= sym_cnt_r + 1'b1;
    end
  end

  assign timing_en_o  = timing_en_r;
  assign cfo_en_o     = cfo_en_r;
  assign carrier_en_o = carrier_en_r;
  assign freq_load_o  = freq_load_r;
  assign freq_word_o  = freq_word_r;
  assign lock_o       = lock_r;
  assign acq_fail_o   = acq_fail_r;
  assign state_o      = state_r;

endmodule

// File: tb/tb_msk_rx_acq_ctrl.sv
// Self-checking bench for msk_rx_acq_ctrl with a run-length reference model.
module tb_msk_rx_acq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, start_i, sym_val_i, ted_val_i, cfo_done_i, ped_val_i;
  logic [17:0] ted_err_i;
  logic [31:0] cfo_word_i;
  logic [23:0] ped_err_i;
  logic        timing_en_o, cfo_en_o, carrier_en_o, freq_load_o, lock_o, acq_fail_o;
  logic [31:0] freq_word_o;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  msk_rx_acq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .sym_val_i(sym_val_i),
    .ted_err_i(ted_err_i), .ted_val_i(ted_val_i), .cfo_done_i(cfo_done_i),
    .cfo_word_i(cfo_word_i), .ped_err_i(ped_err_i), .ped_val_i(ped_val_i),
    .timing_en_o(timing_en_o), .cfo_en_o(cfo_en_o), .carrier_en_o(carrier_en_o),
    .freq_load_o(freq_load_o), .freq_word_o(freq_word_o), .lock_o(lock_o),
    .acq_fail_o(acq_fail_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: state number plus current run lengths and symbol count.
  int          m_state;
  longint      m_tg, m_tb, m_pg, m_pb, m_sym;
  logic [31:0] m_word;
  bit          m_load, m_fail;

  task automatic model_reset();
    m_state = 0; m_tg = 0; m_tb = 0; m_pg = 0; m_pb = 0; m_sym = 0;
    m_word = 32'd0; m_load = 1'b0; m_fail = 1'b0;
  endtask

  function automatic bit is_good(longint x, int w, longint thr);
    longint mn = -(longint'(1) << (w - 1));
    if (x == mn) return 1'b0;
    return ((x < 0) ? -x : x) < thr;
  endfunction

  task automatic model_step();
    int     nxt = m_state;
    bit     fail = 1'b0, latch = 1'b0, tgood, pgood, tmo;
    longint tg = m_tg, tb = m_tb, pg = m_pg, pb = m_pb, sym, to;
    tgood = is_good(longint'($signed(ted_err_i)), 18, 2048);
    pgood = is_good(longint'($signed(ped_err_i)), 24, 65536);
    if (ted_val_i) begin if (tgood) begin tg++; tb = 0; end else begin tb++; tg = 0; end end
    if (ped_val_i) begin if (pgood) begin pg++; pb = 0; end else begin pb++; pg = 0; end end
    sym = m_sym + (sym_val_i ? 1 : 0);
    to  = (m_state == 1) ? 4096 : (m_state == 2) ? 1024 : (m_state == 3) ? 4096 : 0;
    tmo = sym_val_i && (to != 0) && (sym >= to);
    if (!start_i) nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 2 && cfo_done_i) begin nxt = 3; latch = 1'b1; end
    else if (tmo) begin fail = 1'b1; nxt = (m_state == 3) ? 2 : 1; end
    else if (m_state == 1 && ted_val_i && tgood && tg >= 64) nxt = 2;
    else if (m_state == 3 && ped_val_i && pgood && pg >= 128) nxt = 4;
    else if (m_state == 4 && ted_val_i && !tgood && tb >= 32) nxt = 1;
    else if (m_state == 4 && ped_val_i && !pgood && pb >= 32) nxt = 3;
    if (latch) m_word = cfo_word_i;
    m_load = (nxt == 3) && (nxt != m_state);
    if (nxt != m_state || fail) begin
      m_tg = 0; m_tb = 0; m_pg = 0; m_pb = 0; m_sym = 0;
    end else begin
      m_tg = tg; m_tb = tb; m_pg = pg; m_pb = pb; m_sym = sym;
    end
    m_state = nxt;
    m_fail  = fail;
  endtask

  function automatic logic [8:0] exp_outs();
    return {3'(m_state), m_state != 0, m_state == 2, (m_state == 3) || (m_state == 4),
            m_load, m_state == 4, m_fail};
  endfunction

  function automatic logic [8:0] dut_outs();
    return {state_o, timing_en_o, cfo_en_o, carrier_en_o, freq_load_o, lock_o, acq_fail_o};
  endfunction

  function automatic logic [17:0] ted_good();
    int v = int'($urandom_range(0, 4094)) - 2047;
    return 18'(v);
  endfunction

  function automatic logic [17:0] ted_bad();
    int v = int'($urandom_range(2048, 131071));
    if ($urandom_range(0, 7) == 0) return 18'h20000;
    if ($urandom_range(0, 1) == 1) v = -v;
    return 18'(v);
  endfunction

  function automatic logic [23:0] ped_good();
    int v = int'($urandom_range(0, 131070)) - 65535;
    return 24'(v);
  endfunction

  function automatic logic [23:0] ped_bad();
    int v = int'($urandom_range(65536, 8388607));
    if ($urandom_range(0, 7) == 0) return 24'h800000;
    if ($urandom_range(0, 1) == 1) v = -v;
    return 24'(v);
  endfunction

  // Advance one clock: model sees the same inputs the DUT samples.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = 1'b1; sym_val_i = 1'b0; ted_val_i = 1'b0; ted_err_i = 18'd0;
    cfo_done_i = 1'b0; cfo_word_i = 32'd0; ped_val_i = 1'b0; ped_err_i = 24'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    start_i = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_outs() !== 9'd0) begin errors++; $display("FAIL reset_outs: got %b want %b", dut_outs(), 9'd0); end
    checks++;
    if (freq_word_o !== 32'd0) begin errors++; $display("FAIL reset_word: got %h want 0", freq_word_o); end
    reset_n = 1'b1;
    tick();
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", state_o); end
  endtask

  task automatic test_timing_acq();
    start_i = 1'b1; sym_val_i = 1'b1; ted_val_i = 1'b1; ted_err_i = 18'd0;
    tick();
    checks++;
    if (state_o !== 3'd1 || timing_en_o !== 1'b1) begin errors++; $display("FAIL tim_enter: got state %0d en %b want 1 1", state_o, timing_en_o); end
    for (int i = 1; i < 64; i++) begin
      tick();
      checks++;
      if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL tim_run %0d: got %b want %b", i, dut_outs(), exp_outs()); end
    end
    tick();
    checks++;
    if (state_o !== 3'd2 || cfo_en_o !== 1'b1) begin errors++; $display("FAIL tim_lock: got state %0d cfo_en %b want 2 1", state_o, cfo_en_o); end
  endtask

  task automatic test_cfo_load();
    ted_val_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sym_val_i = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL cfo_wait %0d: got %b want %b", i, dut_outs(), exp_outs()); end
    end
    cfo_done_i = 1'b1; cfo_word_i = 32'h00123456;
    tick();
    checks++;
    if (freq_word_o !== 32'h00123456 || freq_load_o !== 1'b1 || state_o !== 3'd3) begin
      errors++; $display("FAIL cfo_latch: got word %h load %b state %0d want 00123456 1 3", freq_word_o, freq_load_o, state_o);
    end
    cfo_done_i = 1'b0; cfo_word_i = $urandom;
    tick();
    checks++;
    if (freq_load_o !== 1'b0 || freq_word_o !== 32'h00123456) begin
      errors++; $display("FAIL cfo_hold: got load %b word %h want 0 00123456", freq_load_o, freq_word_o);
    end
  endtask

  task automatic test_carrier_lock();
    ted_val_i = 1'b1; ped_val_i = 1'b1; ped_err_i = 24'd100; sym_val_i = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      ted_err_i = ted_good();
      tick();
      checks++;
      if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL car_run %0d: got %b want %b", i, dut_outs(), exp_outs()); end
    end
    checks++;
    if (lock_o !== 1'b1 || state_o !== 3'd4) begin errors++; $display("FAIL car_lock: got lock %b state %0d want 1 4", lock_o, state_o); end
    ped_err_i = 24'h7FFFFF;
    for (int i = 1; i <= 32; i++) begin
      ted_err_i = ted_good();
      tick();
      checks++;
      if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL ped_unlock %0d: got %b want %b", i, dut_outs(), exp_outs()); end
    end
    checks++;
    if (lock_o !== 1'b0 || state_o !== 3'd3 || freq_load_o !== 1'b1) begin
      errors++; $display("FAIL ped_unlock_end: got lock %b state %0d load %b want 0 3 1", lock_o, state_o, freq_load_o);
    end
  endtask

  task automatic test_both_unlock();
    for (int i = 0; i < 128; i++) begin
      ted_err_i = ted_good(); ped_err_i = ped_good();
      tick();
    end
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL relock: got %0d want 4", state_o); end
    for (int i = 1; i <= 32; i++) begin
      ted_err_i = ted_bad(); ped_err_i = ped_bad();
      tick();
      checks++;
      if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL both_unlock %0d: got %b want %b", i, dut_outs(), exp_outs()); end
    end
    checks++;
    if (state_o !== 3'd1 || carrier_en_o !== 1'b0) begin errors++; $display("FAIL ted_wins: got state %0d car_en %b want 1 0", state_o, carrier_en_o); end
  endtask

  task automatic test_ted_timeout();
    int fails = 0;
    ped_val_i = 1'b0; ted_val_i = 1'b1; ted_err_i = 18'h20000;
    for (int s = 1; s <= 4096; s++) begin
      sym_val_i = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 1)); g++) begin
        tick();
        if (acq_fail_o === 1'b1) fails++;
      end
      sym_val_i = 1'b1;
      tick();
      if (acq_fail_o === 1'b1) fails++;
      checks++;
      if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL ted_to sym %0d: got %b want %b", s, dut_outs(), exp_outs()); end
    end
    checks++;
    if (acq_fail_o !== 1'b1 || state_o !== 3'd1) begin errors++; $display("FAIL ted_to_end: got fail %b state %0d want 1 1", acq_fail_o, state_o); end
    checks++;
    if (fails != 1) begin errors++; $display("FAIL ted_to_count: got %0d pulses want 1", fails); end
    sym_val_i = 1'b0;
  endtask

  task automatic acquire_timing();
    ted_val_i = 1'b1; sym_val_i = 1'b0; ped_val_i = 1'b0;
    for (int i = 0; i < 64; i++) begin ted_err_i = ted_good(); tick(); end
    ted_val_i = 1'b0;
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL reacquire: got %0d want 2", state_o); end
  endtask

  task automatic test_cfo_timeout_and_race();
    acquire_timing();
    sym_val_i = 1'b1;
    for (int s = 1; s < 1024; s++) tick();
    checks++;
    if (state_o !== 3'd2 || acq_fail_o !== 1'b0) begin errors++; $display("FAIL cfo_to_pre: got state %0d fail %b want 2 0", state_o, acq_fail_o); end
    tick();
    checks++;
    if (state_o !== 3'd1 || acq_fail_o !== 1'b1) begin errors++; $display("FAIL cfo_to: got state %0d fail %b want 1 1", state_o, acq_fail_o); end
    acquire_timing();
    sym_val_i = 1'b1;
    for (int s = 1; s < 1024; s++) tick();
    cfo_done_i = 1'b1; cfo_word_i = $urandom;
    tick();
    cfo_done_i = 1'b0;
    checks++;
    if (dut_outs() !== {3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL done_wins: got %b want %b", dut_outs(), {3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    checks++;
    if (freq_word_o !== m_word) begin errors++; $display("FAIL done_word: got %h want %h", freq_word_o, m_word); end
  endtask

  task automatic test_start_low();
    ted_val_i = 1'b1; ped_val_i = 1'b1; sym_val_i = 1'b0;
    for (int i = 0; i < 128; i++) begin ted_err_i = ted_good(); ped_err_i = ped_good(); tick(); end
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL lock_before_stop: got %0d want 4", state_o); end
    start_i = 1'b0;
    tick();
    checks++;
    if (dut_outs() !== 9'd0) begin errors++; $display("FAIL stop_outs: got %b want 0", dut_outs()); end
    checks++;
    if (freq_word_o !== m_word) begin errors++; $display("FAIL stop_word: got %h want %h", freq_word_o, m_word); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    tick();
    acquire_timing();
    cfo_done_i = 1'b1; cfo_word_i = $urandom | 32'h1;
    tick();
    cfo_done_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL pre_reset_state: got %0d want 3", state_o); end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_outs() !== 9'd0 || freq_word_o !== 32'd0) begin
      errors++; $display("FAIL async_reset: got %b word %h want 0 0", dut_outs(), freq_word_o);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_ted_boundary();
    ted_val_i = 1'b1; sym_val_i = 1'b0;
    tick();
    for (int i = 0; i < 63 + 1 + 64; i++) begin
      if (i < 63)       ted_err_i = (i % 2 == 0) ? 18'h007FF : 18'h3F801;
      else if (i == 63) ted_err_i = (($urandom_range(0, 1) == 1) ? 18'h00800 : 18'h3F800);
      else              ted_err_i = ted_good();
      tick();
      checks++;
      if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL ted_bound %0d: got %b want %b", i, dut_outs(), exp_outs()); end
    end
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL ted_bound_end: got %0d want 2", state_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      start_i    = ($urandom_range(0, 999) != 0);
      sym_val_i  = 1'($urandom_range(0, 1));
      ted_val_i  = ($urandom_range(0, 9) < 8);
      ted_err_i  = ($urandom_range(0, 99) < 3) ? ted_bad() : ted_good();
      ped_val_i  = ($urandom_range(0, 9) < 8);
      ped_err_i  = ($urandom_range(0, 199) == 0) ? ped_bad() : ped_good();
      cfo_done_i = ($urandom_range(0, 49) == 0);
      cfo_word_i = $urandom;
      tick();
      checks++;
      if (dut_outs() !== exp_outs() || freq_word_o !== m_word) begin
        errors++; $display("FAIL random %0d: got %b/%h want %b/%h", i, dut_outs(), freq_word_o, exp_outs(), m_word);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing_acq();
    test_cfo_load();
    test_carrier_lock();
    test_both_unlock();
    test_ted_timeout();
    test_cfo_timeout_and_race();
    test_start_low();
    test_reset_mid();
    test_ted_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/msk_rx_acq_ctrl.md
# msk_rx_acq_ctrl

Acquisition sequencer for the MSK receive chain. It brings up the symbol-timing loop (Gardner TED, PI filter, phase accumulator), then the coarse CFO estimator, then the carrier loop (derotator, phase detector, CFO loop filter, NCO), in that order. It qualifies each stage with a lock detector and publishes the overall lock state. On loss of lock or timeout it drops back to the appropriate stage. It sits beside the RX datapath and drives that chain's enable and load strobes.

## Interface
- TED_W, 18, timing error width (signed)
- PED_W, 24, phase detector error width (signed)
- FW, 32, frequency word width
- CNT_W, 16, width of all internal counters
- TED_THR, 2048, timing-lock magnitude threshold
- TED_LOCK_N, 64, consecutive good TED samples needed for timing lock
- PED_THR, 65536, carrier-lock magnitude threshold
- PED_LOCK_N, 128, consecutive good PED samples needed for carrier lock
- UNLOCK_N, 32, consecutive bad samples that declare loss of lock
- TIM_TO, 4096, timing-acquisition timeout in symbols
- CFO_TO, 1024, CFO-estimate timeout in symbols
- CAR_TO, 4096, carrier-acquisition timeout in symbols

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- start_i  in  1  level enable; low forces IDLE
- sym_val_i  in  1  one-cycle strobe per symbol (timeout base)
- ted_err_i  in  TED_W  signed timing error
- ted_val_i  in  1  ted_err_i qualifier
- cfo_done_i  in  1  coarse CFO estimate ready (pulse)
- cfo_word_i  in  FW  signed coarse frequency word, valid with cfo_done_i
- ped_err_i  in  PED_W  signed phase error
- ped_val_i  in  1  ped_err_i qualifier
- timing_en_o  out  1  timing loop run
- cfo_en_o  out  1  coarse CFO estimator enable
- carrier_en_o  out  1  derotator/phase-detector/loop-filter enable
- freq_load_o  out  1  one-cycle load of freq_word_o into the CFO loop integrator
- freq_word_o  out  FW  latched coarse frequency word
- lock_o  out  1  full lock (state LOCKED)
- acq_fail_o  out  1  one-cycle pulse on any timeout
- state_o  out  3  current state encoding

## Operation
- States and encodings: IDLE=0, TIM_ACQ=1, CFO_EST=2, CAR_ACQ=3, LOCKED=4. Moore outputs.
- IDLE: all enables 0. start_i=1 -> TIM_ACQ.
- TIM_ACQ: timing_en_o=1.
  - TED good-run reaches TED_LOCK_N -> CFO_EST.
  - Symbol count reaches TIM_TO -> acq_fail_o, re-enter TIM_ACQ with counters cleared.
- CFO_EST: timing_en_o=1, cfo_en_o=1.
  - cfo_done_i -> latch cfo_word_i into freq_word_o, then CAR_ACQ.
  - CFO_TO symbols elapse -> fail, go to TIM_ACQ.
- CAR_ACQ: timing_en_o=1, carrier_en_o=1.
  - freq_load_o=1 on the first cycle only.
  - PED good-run reaches PED_LOCK_N -> LOCKED.
  - CAR_TO elapses -> fail, go to CFO_EST.
- LOCKED: timing_en_o=1, carrier_en_o=1, lock_o=1.
  - PED bad-run reaches UNLOCK_N -> CAR_ACQ.
  - TED bad-run reaches UNLOCK_N -> TIM_ACQ. TED wins if both fire together.
- Good sample: |err| < THR. Bad sample: otherwise. A good sample clears the bad-run counter, and a bad sample clears the good-run counter.
- |most-negative| saturates to the positive maximum and always counts as bad.
- All counters saturate and clear on every state entry.
- Priority, highest first: start_i low > cfo_done_i > timeout > lock/unlock.

## Timing
- Reset: state IDLE; all outputs 0; freq_word_o=0.
- State changes on the clock edge after the qualifying event (1-cycle latency). Enables and state_o change on that same edge.
- freq_load_o is high exactly 1 cycle, coincident with the first CAR_ACQ cycle. freq_word_o is stable from that cycle until the next load.
- acq_fail_o is high 1 cycle, coincident with the first cycle of the re-entered state.
- Timeouts count sym_val_i only. The TO-th strobe triggers the transition.
- start_i dropping mid-operation: IDLE next cycle; freq_word_o retained.
- Asynchronous reset mid-operation: immediate return to reset values.

## Structure
- Package msk_rx_acq_pkg holds:
  - the state enum (3-bit, encodings above);
  - the parameter defaults as localparams;
  - a saturating-abs function.
- Sub-module msk_lock_det(W, THR, N_GOOD, N_BAD): magnitude compare plus good-run/bad-run counters, with outputs good_hit and bad_hit. Instantiated once for TED and once for PED, each with a synchronous clear driven on state entry.

## Test plan
- Reset, start_i=1, ted_err=0 on every symbol: TIM_ACQ after 1 cycle, CFO_EST after the 64th ted_val_i.
- In CFO_EST, cfo_done_i with cfo_word_i=0x00123456: freq_word_o=0x00123456; freq_load_o pulses once in the first CAR_ACQ cycle.
- PED error=100 ×128 -> lock_o=1 and state_o=4. Then PED error=0x7FFFFF ×32 -> lock_o=0 and state_o=3 on the next edge.
- TED error=-2^17 held in TIM_ACQ: never locks; acq_fail_o pulses at the 4096th sym_val_i; state_o stays 1.
- cfo_done_i coincident with the 1024th symbol in CFO_EST: done wins, CAR_ACQ entered, no acq_fail_o.
- start_i low in LOCKED, and separately a reset_n pulse mid-CAR_ACQ: IDLE with all enables 0. The freq_word_o value is retained after start_i low and cleared after reset.
